// File: rtl/i2c_tgt_pkg.sv
// i2c_tgt_pkg: shared state encoding and sizing for the I2C register target
package i2c_tgt_pkg;
   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
   } state_t;
   localparam int FILT_LEN_DEF = 3;
   localparam int REG_CNT = 8;
   localparam int IDX_W = 3;
endpackage

// File: rtl/i2c_line_filter.sv
// i2c_line_filter: 2-FF synchronizer plus run-length glitch filter with edge pulses
module i2c_line_filter #(
   parameter int FILT_LEN = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic rise,
   output logic fall
);
   localparam int CW = FILT_LEN > 1 ? $clog2(FILT_LEN) : 1;
   logic s1, s2;
   logic [CW-1:0] cnt;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         s1 <= 1'b1;
         s2 <= 1'b1;
         level <= 1'b1;
         cnt <= '0;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         s1 <= raw;
         s2 <= s1;
         rise <= 1'b0;
         fall <= 1'b0;
         if (s2 == level) cnt <= '0;
         else if (cnt == CW'(FILT_LEN - 1)) begin
            level <= s2;
            rise <= s2;
            fall <= ~s2;
            cnt <= '0;
         end else cnt <= cnt + 1'b1;
      end
endmodule

// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target exposing eight 8-bit registers with auto-incrementing pointer
module i2c_target_regs
   import i2c_tgt_pkg::*;
#(
   parameter logic [6:0] TGT_ADDR = 7'h50,
   parameter int FILT_LEN = FILT_LEN_DEF
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             SCL_I,
   input  logic             SDA_I,
   output logic             SDA_OE,
   output logic [63:0]      REGS,
   output logic             WR_STB,
   output logic [IDX_W-1:0] WR_IDX,
   output logic             BUSY
);
   logic scl, sda, scl_rise, scl_fall, sda_rise, sda_fall;
   logic start, stop, fall_d, rw, byte_done;
   logic [3:0] bit_cnt;
   logic [7:0] shreg, wbyte;
   logic [IDX_W-1:0] ptr;
   logic [REG_CNT-1:0][7:0] regs;
   state_t state;

   i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl (
      .clk(CLK), .rst(RESET), .raw(SCL_I), .level(scl), .rise(scl_rise), .fall(scl_fall)
   );
   i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda (
      .clk(CLK), .rst(RESET), .raw(SDA_I), .level(sda), .rise(sda_rise), .fall(sda_fall)
   );

   assign start = sda_fall & scl;
   assign stop = sda_rise & scl;
   assign wbyte = {shreg[6:0], sda};
   assign byte_done = scl_rise && bit_cnt == 4'd7;
   assign REGS = regs;

   always_ff @(posedge CLK or posedge RESET)
      if (RESET) begin
         state <= IDLE;
         bit_cnt <= '0;
         shreg <= '0;
         ptr <= '0;
         regs <= '0;
         rw <= 1'b0;
         fall_d <= 1'b0;
         SDA_OE <= 1'b0;
         WR_STB <= 1'b0;
         WR_IDX <= '0;
         BUSY <= 1'b0;
      end else begin
         fall_d <= scl_fall;
         WR_STB <= 1'b0;
         // kept outside the START/STOP priority chain so a completed byte always lands
         if (state == WDATA && byte_done) begin
            regs[ptr] <= wbyte;
            WR_STB <= 1'b1;
            WR_IDX <= ptr;
            ptr <= ptr + 1'b1;
         end
         if (start) begin
            state <= ADDR;
            bit_cnt <= '0;
            SDA_OE <= 1'b0;
            BUSY <= 1'b1;
         end else if (stop) begin
            state <= IDLE;
            SDA_OE <= 1'b0;
            BUSY <= 1'b0;
         end else if (scl_rise) begin
            bit_cnt <= byte_done ? '0 : bit_cnt + 1'b1;
            if (state inside {ADDR, PTR, WDATA}) shreg <= wbyte;
            if (byte_done)
               case (state)
                  ADDR: begin
                     rw <= sda;
                     state <= shreg[6:0] == TGT_ADDR ? ADDR_ACK : WAIT_STOP;
                  end
                  PTR: begin
                     ptr <= wbyte[IDX_W-1:0];
                     state <= PTR_ACK;
                  end
                  WDATA: state <= WDATA_ACK;
                  RDATA: state <= RDATA_ACK;
                  default: ;
               endcase
            if (state == RDATA_ACK) begin
               if (sda) state <= WAIT_STOP;
               else ptr <= ptr + 1'b1;
            end
         end else if (fall_d)
            case (state)
               // bit_cnt==0: fall ending the 8th bit; otherwise the fall ending the ACK slot
               ADDR_ACK, PTR_ACK, WDATA_ACK, RDATA_ACK:
                  if (bit_cnt == '0) SDA_OE <= state != RDATA_ACK;
                  else begin
                     bit_cnt <= '0;
                     if (state == RDATA_ACK || (state == ADDR_ACK && rw)) begin
                        state <= RDATA;
                        shreg <= regs[ptr];
                        SDA_OE <= ~regs[ptr][7];
                     end else begin
                        state <= state == ADDR_ACK ? PTR : WDATA;
                        SDA_OE <= 1'b0;
                     end
                  end
               RDATA: begin
                  shreg <= shreg << 1;
                  SDA_OE <= ~shreg[6];
               end
               default: ;
            endcase
      end
endmodule

// File: tb/tb_i2c_target_regs.sv
// tb_i2c_target_regs: directed I2C master transactions with immediate-assertion checks
module tb_i2c_target_regs;
   localparam int Q = 12;
   logic CLK = 1'b0, RESET = 1'b1;
   logic scl_m = 1'b1, sda_m = 1'b1, glitch = 1'b0, glitch_en = 1'b0;
   logic SDA_OE, WR_STB, BUSY, sda_bus, scl_pin;
   logic [63:0] REGS;
   logic [2:0] WR_IDX;
   logic [2:0] idx_log [8];
   int n_chk = 0, n_fail = 0, stb_cnt = 0;

   assign sda_bus = sda_m & ~SDA_OE;
   assign scl_pin = scl_m ^ glitch;
   always #5 CLK = ~CLK;

   i2c_target_regs dut (
      .CLK(CLK), .RESET(RESET), .SCL_I(scl_pin), .SDA_I(sda_bus), .SDA_OE(SDA_OE),
      .REGS(REGS), .WR_STB(WR_STB), .WR_IDX(WR_IDX), .BUSY(BUSY)
   );

   always @(negedge CLK)
      if (WR_STB) begin
         idx_log[stb_cnt[2:0]] <= WR_IDX;
         stb_cnt <= stb_cnt + 1;
      end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic q();
      for (int i = 0; i < Q; i++) begin
         @(posedge CLK);
         glitch = glitch_en && i == 8;
      end
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; q(); scl_m = 1'b1; q(); sda_m = 1'b0; q(); scl_m = 1'b0; q();
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; q(); scl_m = 1'b1; q(); sda_m = 1'b1; q();
   endtask

   task automatic i2c_bit(input logic b, output logic r);
      sda_m = b; q(); scl_m = 1'b1; q();
      @(negedge CLK);
      r = sda_bus;
      q(); scl_m = 1'b0; q();
   endtask

   task automatic wr_byte(input logic [7:0] d, output logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) i2c_bit(d[i], r);
      i2c_bit(1'b1, ack);
   endtask

   task automatic rd_byte(input logic mack, output logic [7:0] d);
      logic r;
      for (int i = 7; i >= 0; i--) i2c_bit(1'b1, d[i]);
      i2c_bit(mack, r);
   endtask

   initial begin
      logic ack, r;
      logic [7:0] rd;
      logic [7:0] a = 8'hA0;
      repeat (3) @(posedge CLK);
      #1;
      check("rst_sda_oe", SDA_OE, 0);
      check("rst_regs", REGS, 0);
      check("rst_busy", BUSY, 0);
      check("rst_wr_stb", WR_STB, 0);
      check("rst_wr_idx", WR_IDX, 0);
      @(negedge CLK) RESET = 1'b0;
      q();
      i2c_start();
      check("busy_after_start", BUSY, 1);
      wr_byte(8'hA0, ack); check("w1_addr_ack", ack, 0);
      wr_byte(8'h02, ack); check("w1_ptr_ack", ack, 0);
      wr_byte(8'h11, ack); check("w1_d0_ack", ack, 0);
      wr_byte(8'h22, ack); check("w1_d1_ack", ack, 0);
      check("w1_busy_mid", BUSY, 1);
      i2c_stop();
      check("w1_busy_after_stop", BUSY, 0);
      check("w1_regs", REGS, 64'h0000_0000_2211_0000);
      check("w1_stb_cnt", stb_cnt, 2);
      check("w1_idx0", idx_log[0], 2);
      check("w1_idx1", idx_log[1], 3);
      i2c_start();
      wr_byte(8'hA0, ack); check("w2_addr_ack", ack, 0);
      wr_byte(8'h07, ack); check("w2_ptr_ack", ack, 0);
      wr_byte(8'hAA, ack); check("w2_d0_ack", ack, 0);
      wr_byte(8'hBB, ack); check("w2_d1_ack", ack, 0);
      i2c_stop();
      check("w2_regs_wrap", REGS, 64'hAA00_0000_2211_00BB);
      check("w2_idx0", idx_log[2], 7);
      check("w2_idx1", idx_log[3], 0);
      i2c_start();
      wr_byte(8'hA0, ack); check("r_addr_ack", ack, 0);
      wr_byte(8'h02, ack); check("r_ptr_ack", ack, 0);
      i2c_start();
      wr_byte(8'hA1, ack); check("r_raddr_ack", ack, 0);
      rd_byte(1'b0, rd); check("r_byte0", rd, 8'h11);
      rd_byte(1'b1, rd); check("r_byte1", rd, 8'h22);
      check("r_sda_released", SDA_OE, 0);
      check("r_busy", BUSY, 1);
      i2c_stop();
      check("r_no_writes", stb_cnt, 4);
      i2c_start();
      wr_byte(8'hA2, ack); check("nm_addr_nack", ack, 1);
      check("nm_busy", BUSY, 1);
      wr_byte(8'h55, ack); check("nm_data_nack", ack, 1);
      i2c_stop();
      check("nm_busy_after_stop", BUSY, 0);
      check("nm_regs", REGS, 64'hAA00_0000_2211_00BB);
      check("nm_no_writes", stb_cnt, 4);
      glitch_en = 1'b1;
      i2c_start();
      wr_byte(8'hA0, ack); check("g_addr_ack", ack, 0);
      wr_byte(8'h04, ack); check("g_ptr_ack", ack, 0);
      wr_byte(8'h5A, ack); check("g_d_ack", ack, 0);
      i2c_stop();
      glitch_en = 1'b0;
      check("g_regs", REGS, 64'hAA00_005A_2211_00BB);
      check("g_stb_cnt", stb_cnt, 5);
      check("g_idx", idx_log[4], 4);
      i2c_start();
      for (int i = 7; i >= 0; i--) i2c_bit(a[i], r);
      sda_m = 1'b1;
      for (int i = 0; i < 50 && !SDA_OE; i++) @(negedge CLK);
      check("ra_ack_driven", SDA_OE, 1);
      @(negedge CLK) RESET = 1'b1;
      #1;
      check("ra_sda_oe", SDA_OE, 0);
      check("ra_busy", BUSY, 0);
      check("ra_regs", REGS, 0);
      @(negedge CLK) RESET = 1'b0;
      q(); scl_m = 1'b1; q(); scl_m = 1'b0; q();
      check("ra_ignored_oe", SDA_OE, 0);
      check("ra_ignored_busy", BUSY, 0);
      i2c_stop();
      i2c_start();
      wr_byte(8'hA0, ack); check("ra_w_addr_ack", ack, 0);
      wr_byte(8'h01, ack); check("ra_w_ptr_ack", ack, 0);
      wr_byte(8'h77, ack); check("ra_w_d_ack", ack, 0);
      i2c_stop();
      check("ra_regs_after", REGS, 64'h0000_0000_0000_7700);
      i2c_start();
      wr_byte(8'hA0, ack);
      wr_byte(8'h01, ack);
      i2c_start();
      wr_byte(8'hA1, ack); check("ra_r_addr_ack", ack, 0);
      rd_byte(1'b1, rd); check("ra_r_byte", rd, 8'h77);
      i2c_stop();
      check("ra_r_busy", BUSY, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
